player_health_ctrl: RTL

- Downstream consumer of the player movement stage's registered `enemyCollide` / `enemyFace` outputs.
- Converts sustained collision levels into discrete damage events and tracks remaining lives.
- Runs a frame-timed invulnerability window, with sprite blink, after each hit.
- Declares game over and gates the direction inputs fed to the movement stage (`move_enable`).

---
 rtl/player_health_ctrl_pkg.sv | 24 ++
 rtl/player_health_ctrl_timer.sv | 32 +++
 rtl/player_health_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/player_health_ctrl_pkg.sv
// Shared game definitions for the player health controller.
// State encoding, default tuning constants and enemy hitter IDs.
// Imported by player_health_ctrl and its testbench.
package player_health_ctrl_pkg;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        INVULN    = 2'd1,
        GAME_OVER = 2'd2
    } health_state_t;

    localparam int LIVES_INIT_DEF    = 3;
    localparam int LIVES_W_DEF       = 3;
    localparam int INVULN_FRAMES_DEF = 60;
    localparam int BLINK_FRAMES_DEF  = 8;

    // Hitter IDs reported on enemy_face by the movement stage.
    localparam logic [2:0] HITTER_ENEMY1 = 3'd1;
    localparam logic [2:0] HITTER_ENEMY2 = 3'd2;
    localparam logic [2:0] HITTER_ENEMY3 = 3'd3;
    localparam logic [2:0] HITTER_ENEMY4 = 3'd4;
    localparam logic [2:0] HITTER_ENEMY5 = 3'd5;

endpackage

// File: rtl/player_health_ctrl_timer.sv
// Loadable frame down-counter; expire flags the tick that steps count 1->0.
// Latency: count updates one cycle after load/clear/tick; expire is same-cycle.
// No backpressure: ticks arriving at count 0 are dropped.
// Ports: clk, rst, clear, load, load_val, tick -> count, expire.
module frame_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    assign expire = tick && (count == WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/player_health_ctrl.sv
// Player health: collision levels -> hit events, lives, invulnerability blink, game over.
// Latency: every output is registered, one cycle after the sampled input edge.
// No backpressure: enemy_collide is a level, gated by state; restart overrides all.
// Ports: clk, rst, frame_tick, enemy_collide, enemy_face[2:0], restart ->
//        lives, hit_pulse, last_hitter, invulnerable, sprite_visible, game_over, move_enable.
module player_health_ctrl
    import player_health_ctrl_pkg::*;
#(
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int LIVES_W       = LIVES_W_DEF,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF,
    parameter int BLINK_FRAMES  = BLINK_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               enemy_collide,
    input  logic [2:0]         enemy_face,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               hit_pulse,
    output logic [2:0]         last_hitter,
    output logic               invulnerable,
    output logic               sprite_visible,
    output logic               game_over,
    output logic               move_enable
);

    localparam int TW = $clog2(INVULN_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [LIVES_W-1:0] LIVES_LOAD  = LIVES_W'(LIVES_INIT);
    localparam logic [TW-1:0]      INVULN_LOAD = TW'(INVULN_FRAMES);
    localparam logic [BW-1:0]      BLINK_LAST  = BW'(BLINK_FRAMES);

    health_state_t      state, state_n;
    logic [LIVES_W-1:0] lives_n;
    logic               hit_pulse_n;
    logic [2:0]         last_hitter_n;
    logic               sprite_visible_n;
    logic [BW-1:0]      blink_cnt, blink_cnt_n, blink_inc;
    logic               timer_clear, timer_load, timer_tick, timer_expire;
    logic [TW-1:0]      timer_count;

    // Ticks reach the timer only while invulnerable, so a tick coinciding with
    // the hit edge (state still ALIVE) is not counted toward the new window.
    assign timer_tick = frame_tick && (state == INVULN);
    assign blink_inc  = blink_cnt + BW'(1);

    frame_timer #(.WIDTH(TW)) u_invuln_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .load     (timer_load),
        .load_val (INVULN_LOAD),
        .tick     (timer_tick),
        .count    (timer_count),
        .expire   (timer_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ALIVE;
            lives          <= LIVES_LOAD;
            hit_pulse      <= 1'b0;
            last_hitter    <= 3'd0;
            sprite_visible <= 1'b1;
            blink_cnt      <= '0;
            invulnerable   <= 1'b0;
            game_over      <= 1'b0;
            move_enable    <= 1'b1;
        end else begin
            state          <= state_n;
            lives          <= lives_n;
            hit_pulse      <= hit_pulse_n;
            last_hitter    <= last_hitter_n;
            sprite_visible <= sprite_visible_n;
            blink_cnt      <= blink_cnt_n;
            invulnerable   <= (state_n == INVULN);
            game_over      <= (state_n == GAME_OVER);
            move_enable    <= (state_n != GAME_OVER);
        end
    end

    always_comb begin
        state_n          = state;
        lives_n          = lives;
        hit_pulse_n      = 1'b0;
        last_hitter_n    = last_hitter;
        sprite_visible_n = sprite_visible;
        blink_cnt_n      = blink_cnt;
        timer_clear      = 1'b0;
        timer_load       = 1'b0;

        if (restart) begin
            state_n          = ALIVE;
            lives_n          = LIVES_LOAD;
            sprite_visible_n = 1'b1;
            blink_cnt_n      = '0;
            timer_clear      = 1'b1;
        end else begin
            case (state)
                ALIVE: begin
                    if (enemy_collide) begin
                        hit_pulse_n   = 1'b1;
                        last_hitter_n = enemy_face;
                        // <= 1 rather than == 1 keeps lives from ever wrapping.
                        if (lives <= LIVES_W'(1)) begin
                            lives_n          = '0;
                            state_n          = GAME_OVER;
                            sprite_visible_n = 1'b1;
                        end else begin
                            lives_n          = lives - LIVES_W'(1);
                            state_n          = INVULN;
                            sprite_visible_n = 1'b0;
                            blink_cnt_n      = '0;
                            timer_load       = 1'b1;
                        end
                    end
                end
                INVULN: begin
                    if (frame_tick) begin
                        if (timer_expire) begin
                            state_n          = ALIVE;
                            sprite_visible_n = 1'b1;
                            blink_cnt_n      = '0;
                        end else if (blink_inc == BLINK_LAST) begin
                            sprite_visible_n = ~sprite_visible;
                            blink_cnt_n      = '0;
                        end else begin
                            blink_cnt_n = blink_inc;
                        end
                    end
                end
                GAME_OVER: begin
                    sprite_visible_n = 1'b1;
                end
                default: begin
                    state_n = ALIVE;
                end
            endcase
        end
    end

endmodule
